// File: rtl/reg_writeback_if.sv
// Register writeback bus: mode input, ALU write request, multi-load start,
// load data stream, and the register file / PC write port outputs.
// Latency and backpressure belong to the module using it; master = requester, slave = writeback unit.
interface reg_writeback_if;
  logic [4:0]  M;          // processor mode, sampled when a write is accepted

  logic        alu_valid;  // single register write request
  logic        alu_ready;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;

  logic        ldm_start;  // multi-register load start
  logic        ldm_ready;
  logic [15:0] ldm_list;

  logic        mem_valid;  // load data word stream
  logic        mem_ready;
  logic [31:0] mem_data;

  logic [3:0]  w_addr;     // register file write port
  logic [31:0] w_data;
  logic        write_reg;
  logic        write_pc;   // PC write port
  logic [31:0] pc_data;
  logic        ldm_done;   // multi-load completion pulse
  logic        error;      // rejected write pulse

  modport master (
    output M, alu_valid, alu_addr, alu_data, ldm_start, ldm_list, mem_valid, mem_data,
    input  alu_ready, ldm_ready, mem_ready, w_addr, w_data, write_reg, write_pc, pc_data,
           ldm_done, error
  );

  modport slave (
    input  M, alu_valid, alu_addr, alu_data, ldm_start, ldm_list, mem_valid, mem_data,
    output alu_ready, ldm_ready, mem_ready, w_addr, w_data, write_reg, write_pc, pc_data,
           ldm_done, error
  );
endinterface

// File: rtl/reg_writeback.sv
// Register writeback unit: routes ALU writes and multi-register load words to the register file or PC.
// Latency: a write accepted at edge N appears on the write port from N to N+1 (registered).
// Backpressure: ALU accepted only in IDLE, ldm_start only in IDLE with no ALU request, load words only in LDM.
// Ports: clk (rising edge), rst (async, active-low), bus (reg_writeback_if.slave).
module reg_writeback #(
  parameter bit PC_ALIGN = 1'b1  // force pc_data[1:0] to 0 on every PC write
) (
  input logic           clk,
  input logic           rst,
  reg_writeback_if.slave bus
);

  typedef enum logic {IDLE, LDM} state_t;

  state_t      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic        rdy_q, rdy_d;         // IDLE-ready; low until the first edge after reset
  logic        mem_rdy_q, mem_rdy_d;
  logic [3:0]  w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [31:0] pc_data_q, pc_data_d;
  logic        write_reg_q, write_reg_d;
  logic        write_pc_q, write_pc_d;
  logic        ldm_done_q, ldm_done_d;
  logic        error_q, error_d;

  logic        alu_fire, ldm_fire, mem_fire, wr_fire, mode_bad;
  logic [3:0]  ldm_idx, wr_addr;
  logic [31:0] wr_data;
  logic [15:0] list_rest;

  // ALU requests win over ldm_start, so ldm_ready drops combinationally on alu_valid.
  assign bus.alu_ready = rdy_q;
  assign bus.ldm_ready = rdy_q & ~bus.alu_valid;
  assign bus.mem_ready = mem_rdy_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_data    = w_data_q;
  assign bus.pc_data   = pc_data_q;
  assign bus.write_reg = write_reg_q;
  assign bus.write_pc  = write_pc_q;
  assign bus.ldm_done  = ldm_done_q;
  assign bus.error     = error_q;

  assign alu_fire = bus.alu_valid & rdy_q;
  assign ldm_fire = bus.ldm_start & rdy_q & ~bus.alu_valid;
  assign mem_fire = bus.mem_valid & mem_rdy_q;
  assign wr_fire  = alu_fire | mem_fire;
  assign wr_addr  = alu_fire ? bus.alu_addr : ldm_idx;
  assign wr_data  = alu_fire ? bus.alu_data : bus.mem_data;

  // Clearing the lowest set bit: x & (x - 1).
  assign list_rest = list_q & (list_q - 16'd1);

  // Lowest set bit of the remaining load list (scan from the top so the lowest wins).
  always_comb begin
    ldm_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) ldm_idx = 4'(i);
    end
  end

  // Modes that may not write registers; mode 1010 additionally protects r14.
  always_comb begin
    mode_bad = 1'b0;
    if (!bus.M[4]) begin
      mode_bad = 1'b1;
    end else begin
      case (bus.M[3:0])
        4'b0100, 4'b0101, 4'b1000, 4'b1001,
        4'b1100, 4'b1101, 4'b1110: mode_bad = 1'b1;
        4'b1010:                   mode_bad = (wr_addr == 4'd14);
        default:                   mode_bad = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    rdy_d       = rdy_q;
    mem_rdy_d   = mem_rdy_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    pc_data_d   = pc_data_q;
    write_reg_d = 1'b0;
    write_pc_d  = 1'b0;
    ldm_done_d  = 1'b0;
    error_d     = 1'b0;

    // PC writes ignore the mode; rejected register writes leave the port values untouched.
    if (wr_fire) begin
      if (wr_addr == 4'd15) begin
        write_pc_d = 1'b1;
        pc_data_d  = PC_ALIGN ? {wr_data[31:2], 2'b00} : wr_data;
      end else if (mode_bad) begin
        error_d = 1'b1;
      end else begin
        write_reg_d = 1'b1;
        w_addr_d    = wr_addr;
        w_data_d    = wr_data;
      end
    end

    case (state_q)
      IDLE: begin
        rdy_d     = 1'b1;
        mem_rdy_d = 1'b0;
        if (ldm_fire) begin
          if (bus.ldm_list == 16'd0) begin
            ldm_done_d = 1'b1;
          end else begin
            list_d    = bus.ldm_list;
            state_d   = LDM;
            rdy_d     = 1'b0;
            mem_rdy_d = 1'b1;
          end
        end
      end
      LDM: begin
        // A rejected word still consumes its list bit.
        if (mem_fire) begin
          list_d = list_rest;
          if (list_rest == 16'd0) begin
            state_d    = IDLE;
            rdy_d      = 1'b1;
            mem_rdy_d  = 1'b0;
            ldm_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        rdy_d     = 1'b0;
        mem_rdy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      list_q      <= 16'd0;
      rdy_q       <= 1'b0;
      mem_rdy_q   <= 1'b0;
      w_addr_q    <= 4'd0;
      w_data_q    <= 32'd0;
      pc_data_q   <= 32'd0;
      write_reg_q <= 1'b0;
      write_pc_q  <= 1'b0;
      ldm_done_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      rdy_q       <= rdy_d;
      mem_rdy_q   <= mem_rdy_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      pc_data_q   <= pc_data_d;
      write_reg_q <= write_reg_d;
      write_pc_q  <= write_pc_d;
      ldm_done_q  <= ldm_done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed testbench for reg_writeback: reset values, ALU writes, mode rejection,
// multi-register loads with stalls, ALU/LDM arbitration, and reset during a load.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_reg_writeback;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_writeback_if bus ();

  reg_writeback #(.PC_ALIGN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_addr  = 4'd0;
    bus.alu_data  = 32'd0;
    bus.ldm_start = 1'b0;
    bus.ldm_list  = 16'd0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = 32'd0;
  endtask

  task automatic alu(input logic [4:0] m, input logic [3:0] a, input logic [31:0] d);
    bus.M         = m;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = a;
    bus.alu_data  = d;
    tick();
    bus.alu_valid = 1'b0;
  endtask

  task automatic mem_word(input logic [31:0] d);
    bus.mem_valid = 1'b1;
    bus.mem_data  = d;
    tick();
    bus.mem_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.M  = 5'b10000;
    idle_inputs();

    // Reset state
    repeat (2) tick();
    check("rst_write_reg", bus.write_reg, 1'b0);
    check("rst_write_pc",  bus.write_pc,  1'b0);
    check("rst_w_addr",    bus.w_addr,    4'd0);
    check("rst_w_data",    bus.w_data,    32'd0);
    check("rst_pc_data",   bus.pc_data,   32'd0);
    check("rst_ldm_done",  bus.ldm_done,  1'b0);
    check("rst_error",     bus.error,     1'b0);
    check("rst_alu_ready", bus.alu_ready, 1'b0);
    check("rst_ldm_ready", bus.ldm_ready, 1'b0);
    check("rst_mem_ready", bus.mem_ready, 1'b0);

    // Readies still low right after release, high after the first edge
    rst = 1'b1;
    #1;
    check("rel_alu_ready_0", bus.alu_ready, 1'b0);
    tick();
    check("rel_alu_ready_1", bus.alu_ready, 1'b1);
    check("rel_ldm_ready_1", bus.ldm_ready, 1'b1);

    // Plain register write
    alu(5'b10000, 4'd3, 32'hDEADBEEF);
    check("r3_write_reg", bus.write_reg, 1'b1);
    check("r3_w_addr",    bus.w_addr,    4'd3);
    check("r3_w_data",    bus.w_data,    32'hDEADBEEF);
    check("r3_error",     bus.error,     1'b0);
    check("r3_write_pc",  bus.write_pc,  1'b0);
    tick();
    check("r3_pulse_end", bus.write_reg, 1'b0);
    check("r3_hold_addr", bus.w_addr,    4'd3);
    check("r3_hold_data", bus.w_data,    32'hDEADBEEF);

    // PC write, aligned
    alu(5'b10000, 4'd15, 32'h00001003);
    check("pc_write_pc",  bus.write_pc,  1'b1);
    check("pc_data",      bus.pc_data,   32'h00001000);
    check("pc_write_reg", bus.write_reg, 1'b0);
    tick();
    check("pc_pulse_end", bus.write_pc,  1'b0);

    // Mode rejection
    alu(5'b11010, 4'd14, 32'h0000AAAA);
    check("m1010_r14_error", bus.error,     1'b1);
    check("m1010_r14_wreg",  bus.write_reg, 1'b0);
    check("m1010_r14_addr",  bus.w_addr,    4'd3);
    alu(5'b11010, 4'd13, 32'h0000BBBB);
    check("m1010_r13_error", bus.error,     1'b0);
    check("m1010_r13_wreg",  bus.write_reg, 1'b1);
    check("m1010_r13_addr",  bus.w_addr,    4'd13);
    alu(5'b00000, 4'd2, 32'h0000CCCC);
    check("m00000_error",    bus.error,     1'b1);
    check("m00000_wreg",     bus.write_reg, 1'b0);
    tick();
    check("error_pulse_end", bus.error,     1'b0);
    alu(5'b10100, 4'd5, 32'h0000DDDD);
    check("m0100_error",     bus.error,     1'b1);
    alu(5'b11111, 4'd5, 32'h0000EEEE);
    check("m1111_ok_wreg",   bus.write_reg, 1'b1);
    check("m1111_ok_data",   bus.w_data,    32'h0000EEEE);
    alu(5'b00000, 4'd15, 32'h00004006);
    check("bad_mode_pc_wpc", bus.write_pc,  1'b1);
    check("bad_mode_pc_dat", bus.pc_data,   32'h00004004);
    check("bad_mode_pc_err", bus.error,     1'b0);

    // Multi-load 0x8005 with a two-cycle stall before the second word
    bus.M         = 5'b10000;
    bus.ldm_start = 1'b1;
    bus.ldm_list  = 16'h8005;
    #1;
    check("ldm_ready_idle", bus.ldm_ready, 1'b1);
    tick();
    bus.ldm_start = 1'b0;
    bus.ldm_list  = 16'h0000;
    check("ldm_mem_ready",  bus.mem_ready, 1'b1);
    check("ldm_alu_ready",  bus.alu_ready, 1'b0);
    check("ldm_done_early", bus.ldm_done,  1'b0);
    mem_word(32'h11111111);
    check("ldm_a_wreg", bus.write_reg, 1'b1);
    check("ldm_a_addr", bus.w_addr,    4'd0);
    check("ldm_a_data", bus.w_data,    32'h11111111);
    tick();
    check("ldm_stall1_wreg", bus.write_reg, 1'b0);
    tick();
    check("ldm_stall2_wreg", bus.write_reg, 1'b0);
    check("ldm_stall2_rdy",  bus.mem_ready, 1'b1);
    mem_word(32'h22222222);
    check("ldm_b_addr", bus.w_addr,    4'd2);
    check("ldm_b_data", bus.w_data,    32'h22222222);
    check("ldm_b_done", bus.ldm_done,  1'b0);
    mem_word(32'h00002002);
    check("ldm_c_wpc",  bus.write_pc,  1'b1);
    check("ldm_c_pc",   bus.pc_data,   32'h00002000);
    check("ldm_c_wreg", bus.write_reg, 1'b0);
    check("ldm_c_done", bus.ldm_done,  1'b1);
    check("ldm_c_idle", bus.alu_ready, 1'b1);
    check("ldm_c_mrdy", bus.mem_ready, 1'b0);
    tick();
    check("ldm_done_end", bus.ldm_done, 1'b0);

    // ALU and LDM together: ALU first, then an empty-list LDM
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 4'd4;
    bus.alu_data  = 32'h44444444;
    bus.ldm_start = 1'b1;
    bus.ldm_list  = 16'h0000;
    #1;
    check("arb_ldm_ready_lo", bus.ldm_ready, 1'b0);
    tick();
    bus.alu_valid = 1'b0;
    check("arb_alu_wreg", bus.write_reg, 1'b1);
    check("arb_alu_addr", bus.w_addr,    4'd4);
    check("arb_no_done",  bus.ldm_done,  1'b0);
    #1;
    check("arb_ldm_ready_hi", bus.ldm_ready, 1'b1);
    tick();
    bus.ldm_start = 1'b0;
    check("empty_ldm_done", bus.ldm_done,  1'b1);
    check("empty_ldm_wreg", bus.write_reg, 1'b0);
    check("empty_ldm_mrdy", bus.mem_ready, 1'b0);
    tick();
    check("empty_ldm_end",  bus.ldm_done,  1'b0);

    // Rejected word inside a load still consumes its bit
    bus.M         = 5'b11010;
    bus.ldm_start = 1'b1;
    bus.ldm_list  = 16'h4002;
    tick();
    bus.ldm_start = 1'b0;
    mem_word(32'h55555555);
    check("ldm_err_r1_wreg", bus.write_reg, 1'b1);
    check("ldm_err_r1_addr", bus.w_addr,    4'd1);
    mem_word(32'h66666666);
    check("ldm_err_r14_err",  bus.error,     1'b1);
    check("ldm_err_r14_wreg", bus.write_reg, 1'b0);
    check("ldm_err_r14_done", bus.ldm_done,  1'b1);
    check("ldm_err_idle",     bus.alu_ready, 1'b1);

    // Reset during a load aborts it
    bus.M         = 5'b10000;
    bus.ldm_start = 1'b1;
    bus.ldm_list  = 16'h0007;
    tick();
    bus.ldm_start = 1'b0;
    mem_word(32'h77777777);
    check("abort_first_addr", bus.w_addr, 4'd0);
    bus.mem_valid = 1'b1;
    bus.mem_data  = 32'h88888888;
    rst = 1'b0;
    #1;
    check("abort_w_addr",    bus.w_addr,    4'd0);
    check("abort_w_data",    bus.w_data,    32'd0);
    check("abort_pc_data",   bus.pc_data,   32'd0);
    check("abort_write_reg", bus.write_reg, 1'b0);
    check("abort_mem_ready", bus.mem_ready, 1'b0);
    tick();
    check("abort_in_rst_wreg", bus.write_reg, 1'b0);
    rst = 1'b1;
    tick();
    check("abort_rel_alu_rdy", bus.alu_ready, 1'b1);
    check("abort_rel_mem_rdy", bus.mem_ready, 1'b0);
    check("abort_rel_wreg",    bus.write_reg, 1'b0);
    tick();
    check("abort_rel_wreg2",   bus.write_reg, 1'b0);
    check("abort_rel_done",    bus.ldm_done,  1'b0);
    bus.mem_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
